// File: rtl/registrador_pkg.sv
// +----------------------------------------------------------------------+
// | registrador_pkg : op codes and FSM state encoding for the accumulator |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package registrador_pkg;

  localparam logic [2:0] OP_HOLD  = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_CLEAR = 3'd2;
  localparam logic [2:0] OP_SHR1  = 3'd3;
  localparam logic [2:0] OP_SHL1  = 3'd4;
  localparam logic [2:0] OP_ASR1  = 3'd5;
  localparam logic [2:0] OP_SHRN  = 3'd6;
  localparam logic [2:0] OP_ROR1  = 3'd7;

  typedef enum logic [0:0] {
    ST_IDLE     = 1'b0,
    ST_SHIFTING = 1'b1
  } state_t;

endpackage

`default_nettype wire

// File: rtl/registrador_shift_seq_if.sv
// +----------------------------------------------------------------------+
// | registrador_shift_seq_if : control-unit <-> accumulator bus           |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

interface registrador_shift_seq_if #(
  parameter int WIDTH = 5
);
  logic                       op_valid;
  logic [2:0]                 op;
  logic [WIDTH-1:0]           entrada;
  logic                       serial_in;
  logic [$clog2(WIDTH+1)-1:0] shamt;
  logic [WIDTH-1:0]           acumulador;
  logic                       carry;
  logic                       busy;
  logic                       done;

  modport master (
    output op_valid, op, entrada, serial_in, shamt,
    input  acumulador, carry, busy, done
  );

  modport slave (
    input  op_valid, op, entrada, serial_in, shamt,
    output acumulador, carry, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/registrador_shift_ctrl.sv
// +----------------------------------------------------------------------+
// | registrador_shift_ctrl : SHRN sequencer (FSM, count, busy/done)       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module registrador_shift_ctrl
  import registrador_pkg::*;
#(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] n,
  output logic          busy,
  output logic          done,
  output logic          shift_en
);

  state_t        r_state;
  logic [CW-1:0] r_count;
  logic          r_busy;
  logic          r_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            // A zero count completes immediately without entering SHIFTING
            if (n == '0) begin
              r_done <= 1'b1;
            end else begin
              r_count <= n;
              r_busy  <= 1'b1;
              r_state <= ST_SHIFTING;
            end
          end
        end
        ST_SHIFTING: begin
          r_count <= r_count - CW'(1);
          if (r_count == CW'(1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign shift_en = (r_state == ST_SHIFTING);

endmodule

`default_nettype wire

// File: rtl/registrador_shift_seq.sv
// +----------------------------------------------------------------------+
// | registrador_shift_seq : parametrised accumulator, 8 ops + multi-cycle |
// | SHRN. Define REGISTRADOR_SHRN_ARITH_EN for sign-filling SHRN.         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module registrador_shift_seq
  import registrador_pkg::*;
#(
  parameter int               WIDTH     = 5,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  registrador_shift_seq_if.slave bus
);

  localparam int c_SHW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic             w_accept;
  logic             w_start;
  logic             w_shift_en;
  logic             w_busy;
  logic             w_done;
  logic             w_fill;
  logic [c_SHW-1:0] w_n;

  assign w_accept = bus.op_valid && !w_busy;
  assign w_start  = w_accept && (bus.op == OP_SHRN);
  assign w_n      = (bus.shamt > c_SHW'(WIDTH)) ? c_SHW'(WIDTH) : bus.shamt;

`ifdef REGISTRADOR_SHRN_ARITH_EN
  logic r_fill;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fill <= 1'b0;
    end else if (w_start) begin
      r_fill <= r_acc[WIDTH-1];
    end
  end

  assign w_fill = r_fill;
`else
  assign w_fill = 1'b0;
`endif

  registrador_shift_ctrl #(
    .CW (c_SHW)
  ) u_ctrl (
    .clk      (clk),
    .rst      (rst),
    .start    (w_start),
    .n        (w_n),
    .busy     (w_busy),
    .done     (w_done),
    .shift_en (w_shift_en)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc   <= RESET_VAL;
      r_carry <= 1'b0;
    end else if (w_shift_en) begin
      r_acc   <= {w_fill, r_acc[WIDTH-1:1]};
      r_carry <= r_acc[0];
    end else if (w_accept) begin
      case (bus.op)
        OP_LOAD:  r_acc <= bus.entrada;
        OP_CLEAR: begin
          r_acc   <= '0;
          r_carry <= 1'b0;
        end
        OP_SHR1: begin
          r_acc   <= {bus.serial_in, r_acc[WIDTH-1:1]};
          r_carry <= r_acc[0];
        end
        OP_SHL1: begin
          r_acc   <= {r_acc[WIDTH-2:0], bus.serial_in};
          r_carry <= r_acc[WIDTH-1];
        end
        OP_ASR1: begin
          r_acc   <= {r_acc[WIDTH-1], r_acc[WIDTH-1:1]};
          r_carry <= r_acc[0];
        end
        OP_ROR1: begin
          r_acc   <= {r_acc[0], r_acc[WIDTH-1:1]};
          r_carry <= r_acc[0];
        end
        // HOLD, and SHRN whose shifting happens in later cycles
        default: ;
      endcase
    end
  end

  assign bus.acumulador = r_acc;
  assign bus.carry      = r_carry;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;

endmodule

`default_nettype wire

// File: tb/tb_registrador_shift_seq.sv
// +----------------------------------------------------------------------+
// | tb_registrador_shift_seq : directed scoreboard bench, WIDTH=5         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_registrador_shift_seq;

  localparam logic [2:0] HOLD  = 3'd0;
  localparam logic [2:0] LOAD  = 3'd1;
  localparam logic [2:0] CLEAR = 3'd2;
  localparam logic [2:0] SHR1  = 3'd3;
  localparam logic [2:0] SHL1  = 3'd4;
  localparam logic [2:0] SHRN  = 3'd6;
  localparam logic [2:0] ROR1  = 3'd7;

`ifdef REGISTRADOR_SHRN_ARITH_EN
  localparam bit ARITH = 1'b1;
`else
  localparam bit ARITH = 1'b0;
`endif

  typedef struct {
    string      tag;
    logic [4:0] acc;
    logic       carry;
    logic       busy;
    logic       done;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  exp_t sb[$];

  registrador_shift_seq_if #(.WIDTH(5)) bus ();

  registrador_shift_seq #(
    .WIDTH     (5),
    .RESET_VAL (5'b00000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input string field, input logic [4:0] got, input logic [4:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s.%s observed=%b expected=%b", tag, field, got, want);
    end
  endtask

  // Drive one cycle of stimulus, queue the expected post-edge state, then compare
  task automatic step(input logic r, input logic v, input logic [2:0] o, input logic [4:0] d,
                      input logic si, input logic [2:0] sh, input string tag,
                      input logic [4:0] ea, input logic ec, input logic eb, input logic ed);
    exp_t e;
    rst           = r;
    bus.op_valid  = v;
    bus.op        = o;
    bus.entrada   = d;
    bus.serial_in = si;
    bus.shamt     = sh;
    sb.push_back('{tag, ea, ec, eb, ed});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk(e.tag, "acc",   bus.acumulador,     e.acc);
    chk(e.tag, "carry", {4'b0, bus.carry},  {4'b0, e.carry});
    chk(e.tag, "busy",  {4'b0, bus.busy},   {4'b0, e.busy});
    chk(e.tag, "done",  {4'b0, bus.done},   {4'b0, e.done});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    bus.op_valid = 1'b0; bus.op = HOLD; bus.entrada = '0; bus.serial_in = 1'b0; bus.shamt = '0;
    @(posedge clk);
    #1;

    step(1, 0, HOLD,  5'b00000, 0, 3'd0, "reset",     5'b00000, 0, 0, 0);
    step(0, 1, LOAD,  5'b10110, 0, 3'd0, "load",      5'b10110, 0, 0, 0);
    step(0, 1, SHR1,  5'b00000, 1, 3'd0, "shr1",      5'b11011, 0, 0, 0);
    step(0, 1, SHL1,  5'b00000, 0, 3'd0, "shl1",      5'b10110, 1, 0, 0);
    step(0, 1, ROR1,  5'b00000, 0, 3'd0, "ror1",      5'b01011, 0, 0, 0);

    // SHRN by 3; ops offered while busy must be ignored
    step(0, 1, LOAD,  5'b10110, 0, 3'd0, "reload",    5'b10110, 0, 0, 0);
    step(0, 1, SHRN,  5'b00000, 0, 3'd3, "shrn3_acc", 5'b10110, 0, 1, 0);
    step(0, 1, LOAD,  5'b11111, 1, 3'd0, "shrn3_c1",  ARITH ? 5'b11011 : 5'b01011, 0, 1, 0);
    step(0, 1, CLEAR, 5'b00000, 0, 3'd0, "shrn3_c2",  ARITH ? 5'b11101 : 5'b00101, 1, 1, 0);
    step(0, 1, SHL1,  5'b00000, 1, 3'd0, "shrn3_c3",  ARITH ? 5'b11110 : 5'b00010, 1, 0, 1);
    // New op accepted in the done cycle
    step(0, 1, LOAD,  5'b01001, 0, 3'd0, "load_done", 5'b01001, 1, 0, 0);

    step(0, 1, SHRN,  5'b00000, 0, 3'd0, "shrn0",     5'b01001, 1, 0, 1);
    step(0, 0, SHR1,  5'b00000, 1, 3'd0, "idle_hold", 5'b01001, 1, 0, 0);

    // shamt=7 clamps to 5
    step(0, 1, SHRN,  5'b00000, 0, 3'd7, "shrn7_acc", 5'b01001, 1, 1, 0);
    step(0, 0, HOLD,  5'b00000, 0, 3'd0, "shrn7_c1",  5'b00100, 1, 1, 0);
    step(0, 0, HOLD,  5'b00000, 0, 3'd0, "shrn7_c2",  5'b00010, 0, 1, 0);
    step(0, 0, HOLD,  5'b00000, 0, 3'd0, "shrn7_c3",  5'b00001, 0, 1, 0);
    step(0, 0, HOLD,  5'b00000, 0, 3'd0, "shrn7_c4",  5'b00000, 1, 1, 0);
    step(0, 0, HOLD,  5'b00000, 0, 3'd0, "shrn7_c5",  5'b00000, 0, 0, 1);

    // Reset aborts an in-flight SHRN
    step(0, 1, LOAD,  5'b11000, 0, 3'd0, "load2",     5'b11000, 0, 0, 0);
    step(0, 1, SHRN,  5'b00000, 0, 3'd4, "shrn4_acc", 5'b11000, 0, 1, 0);
    step(0, 0, HOLD,  5'b00000, 0, 3'd0, "shrn4_c1",  ARITH ? 5'b11100 : 5'b01100, 0, 1, 0);
    step(1, 0, HOLD,  5'b00000, 0, 3'd0, "rst_mid",   5'b00000, 0, 0, 0);
    step(0, 0, HOLD,  5'b00000, 0, 3'd0, "post_rst",  5'b00000, 0, 0, 0);
    step(0, 1, LOAD,  5'b00011, 0, 3'd0, "load3",     5'b00011, 0, 0, 0);
    step(0, 1, SHRN,  5'b00000, 0, 3'd1, "shrn1_acc", 5'b00011, 0, 1, 0);
    step(0, 0, HOLD,  5'b00000, 0, 3'd0, "shrn1_c1",  5'b00001, 1, 0, 1);

    // SHRN by 2 on a negative value: fill depends on the build
    step(0, 1, LOAD,  5'b10110, 0, 3'd0, "load4",     5'b10110, 1, 0, 0);
    step(0, 1, SHRN,  5'b00000, 0, 3'd2, "shrn2_acc", 5'b10110, 1, 1, 0);
    step(0, 0, HOLD,  5'b00000, 0, 3'd0, "shrn2_c1",  ARITH ? 5'b11011 : 5'b01011, 0, 1, 0);
    step(0, 0, HOLD,  5'b00000, 0, 3'd0, "shrn2_c2",  ARITH ? 5'b11101 : 5'b00101, 1, 0, 1);
    step(0, 0, HOLD,  5'b00000, 0, 3'd0, "after",     ARITH ? 5'b11101 : 5'b00101, 1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
